// File: rtl/bram_read_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// bram_read_sequencer_pkg : shared state encoding and parameter defaults
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bram_read_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int ADDR_W_DEFAULT = 10;
   localparam int RD_LAT_MIN     = 1;
   localparam int RD_LAT_MAX     = 2;

endpackage : bram_read_sequencer_pkg

`default_nettype wire

// File: rtl/bram_read_sequencer_if.sv
// ----------------------------------------------------------------------------
// bram_read_sequencer_if : request/BRAM/status bundle of the read sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bram_read_sequencer_if
   import bram_read_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W-1:0] addrb;
   logic              enb;
   logic              busy;
   logic              done;
   logic              dout_valid;
   logic              pair_valid;

   // Requester side: issues windows, observes BRAM strobes and status.
   modport master (
      output start, base_addr, len,
      input  addrb, enb, busy, done, dout_valid, pair_valid
   );

   modport slave (
      input  start, base_addr, len,
      output addrb, enb, busy, done, dout_valid, pair_valid
   );
endinterface : bram_read_sequencer_if

`default_nettype wire

// File: rtl/bram_read_sequencer_rd_valid_pipe.sv
// ----------------------------------------------------------------------------
// rd_valid_pipe : RD_LAT-deep shift register turning enb into dout_valid
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rd_valid_pipe #(
   parameter int RD_LAT = 1
) (
   input  wire logic readclk_i,
   input  wire logic rst_ni,
   input  wire logic enb_i,
   output logic      dout_valid_o,
   output logic      inflight_o
);
   logic [RD_LAT-1:0] stage_q;

   generate
      if (RD_LAT == 1) begin : g_lat1
         always_ff @(posedge readclk_i or negedge rst_ni) begin
            if (!rst_ni) stage_q <= '0;
            else         stage_q <= enb_i;
         end
         assign inflight_o = 1'b0;
      end else begin : g_latn
         always_ff @(posedge readclk_i or negedge rst_ni) begin
            if (!rst_ni) stage_q <= '0;
            else         stage_q <= {stage_q[RD_LAT-2:0], enb_i};
         end
         // Reads issued but not yet presented on doutb.
         assign inflight_o = |stage_q[RD_LAT-2:0];
      end
   endgenerate

   assign dout_valid_o = stage_q[RD_LAT-1];

endmodule : rd_valid_pipe

`default_nettype wire

// File: rtl/bram_read_sequencer.sv
// ----------------------------------------------------------------------------
// bram_read_sequencer : walks a BRAM address window, aligns valid and pair flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bram_read_sequencer
   import bram_read_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int RD_LAT = RD_LAT_MIN
) (
   input  wire logic              readclk,
   input  wire logic              rst_n,
   bram_read_sequencer_if.slave   bus
);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   REMAIN_ONE = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic              parity_q, parity_d;
   logic              pair_q, pair_d;
   logic              enb;
   logic              dout_valid;
   logic              inflight;
   logic              accept;

   rd_valid_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_valid_pipe (
      .readclk_i    (readclk),
      .rst_ni       (rst_n),
      .enb_i        (enb),
      .dout_valid_o (dout_valid),
      .inflight_o   (inflight)
   );

   always_ff @(posedge readclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         parity_q <= 1'b0;
         pair_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         parity_q <= parity_d;
         pair_q   <= pair_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE reports busy=0, so a new window may be accepted there too.
            if (state_q == ST_DONE) state_d = ST_IDLE;
            if (bus.start) begin
               accept = 1'b1;
               if (bus.len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_READ;
                  addr_d   = bus.base_addr;
                  remain_d = bus.len;
               end
            end
         end
         ST_READ: begin
            if (remain_q == REMAIN_ONE) begin
               state_d = ST_DRAIN;
            end else begin
               addr_d   = addr_q + ADDR_ONE;
               remain_d = remain_q - REMAIN_ONE;
            end
         end
         ST_DRAIN: begin
            if (dout_valid && !inflight) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // parity_q=1 marks the word now on doutb as the odd (newer) half of a pair.
   always_comb begin
      parity_d = parity_q;
      if (accept)          parity_d = 1'b0;
      else if (dout_valid) parity_d = ~parity_q;
      pair_d = dout_valid & parity_q;
   end

   assign enb            = (state_q == ST_READ);
   assign bus.enb        = enb;
   assign bus.addrb      = addr_q;
   assign bus.busy       = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.dout_valid = dout_valid;
   assign bus.pair_valid = pair_q;

endmodule : bram_read_sequencer

`default_nettype wire

// File: tb/tb_bram_read_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bram_read_sequencer : scoreboard bench for RD_LAT=1 and RD_LAT=2 instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bram_read_sequencer;
   import bram_read_sequencer_pkg::*;

   localparam int AW = 10;
   typedef logic [AW+4:0] vec_t;  // {addrb, enb, busy, done, dout_valid, pair_valid}

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bram_read_sequencer_if #(.ADDR_W(AW)) bus1 ();
   bram_read_sequencer_if #(.ADDR_W(AW)) bus2 ();

   bram_read_sequencer #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
      .readclk (clk),
      .rst_n   (rst_n),
      .bus     (bus1)
   );

   bram_read_sequencer #(.ADDR_W(AW), .RD_LAT(2)) u_dut2 (
      .readclk (clk),
      .rst_n   (rst_n),
      .bus     (bus2)
   );

   int            vectors     = 0;
   int            miscompares = 0;
   vec_t          q1[$];
   vec_t          q2[$];
   logic [AW-1:0] hold1 = '0;
   logic [AW-1:0] hold2 = '0;

   function automatic vec_t obs1();
      return {bus1.addrb, bus1.enb, bus1.busy, bus1.done, bus1.dout_valid, bus1.pair_valid};
   endfunction

   function automatic vec_t obs2();
      return {bus2.addrb, bus2.enb, bus2.busy, bus2.done, bus2.dout_valid, bus2.pair_valid};
   endfunction

   // Expected outputs for the cycles after edges E0 .. E0+lat+len, derived
   // from the timing equations; idle cycles afterwards hold the last address.
   function automatic void push_seq(int d, logic [AW-1:0] base, int len, int lat);
      vec_t          v;
      logic [AW-1:0] a;
      if (len == 0) begin
         v = {(d == 1) ? hold1 : hold2, 5'b00100};
         if (d == 1) q1.push_back(v); else q2.push_back(v);
         return;
      end
      for (int k = 0; k <= lat + len; k++) begin
         int m;
         m = k - lat;
         a = (k < len) ? base + AW'(k) : base + AW'(len - 1);
         v = {a, (k < len), (k <= lat + len - 1), (k == lat + len),
              (m >= 0 && m < len), (m >= 2 && (m % 2) == 0 && (m - 1) < len)};
         if (d == 1) q1.push_back(v); else q2.push_back(v);
      end
      if (d == 1) hold1 = base + AW'(len - 1);
      else        hold2 = base + AW'(len - 1);
   endfunction

   function automatic vec_t pop1();
      if (q1.size() > 0) return q1.pop_front();
      return {hold1, 5'b00000};
   endfunction

   function automatic vec_t pop2();
      if (q2.size() > 0) return q2.pop_front();
      return {hold2, 5'b00000};
   endfunction

   task automatic test_reset();
      vec_t o;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      o = obs1();
      vectors++;
      if (o !== '0) begin
         miscompares++;
         $display("FAIL reset_lat1: got %h expected %h", o, vec_t'(0));
      end
      o = obs2();
      vectors++;
      if (o !== '0) begin
         miscompares++;
         $display("FAIL reset_lat2: got %h expected %h", o, vec_t'(0));
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      vec_t e, o;
      @(negedge clk);
      e = pop1(); o = obs1();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL basic_pre: got %h expected %h", o, e);
      end
      bus1.base_addr = 10'h010;
      bus1.len       = 11'd4;
      bus1.start     = 1'b1;
      push_seq(1, 10'h010, 4, 1);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         bus1.start = 1'b0;
         e = pop1(); o = obs1();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL basic_cyc%0d: got %h expected %h", c, o, e);
         end
      end
   endtask

   // Window table: address wrap, empty window, single word.
   task automatic test_windows();
      logic [AW-1:0] bases [3] = '{10'h3FE, 10'h123, 10'h3FF};
      int            lens  [3] = '{3, 0, 1};
      vec_t          e, o;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         e = pop1(); o = obs1();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL win%0d_pre: got %h expected %h", t, o, e);
         end
         bus1.base_addr = bases[t];
         bus1.len       = 11'(lens[t]);
         bus1.start     = 1'b1;
         push_seq(1, bases[t], lens[t], 1);
         for (int c = 0; c < lens[t] + 5; c++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            e = pop1(); o = obs1();
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL win%0d_cyc%0d: got %h expected %h", t, c, o, e);
            end
         end
      end
   endtask

   // start held high from E0 onward: ignored while busy, relaunches in DONE.
   task automatic test_back_to_back();
      vec_t e, o;
      bit   launched = 1'b0;
      @(negedge clk);
      e = pop1(); o = obs1();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL b2b_pre: got %h expected %h", o, e);
      end
      bus1.base_addr = 10'h200;
      bus1.len       = 11'd3;
      bus1.start     = 1'b1;
      push_seq(1, 10'h200, 3, 1);
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         e = pop1(); o = obs1();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL b2b_cyc%0d: got %h expected %h", c, o, e);
         end
         if (c == 0) begin
            bus1.base_addr = 10'h300;
            bus1.len       = 11'd2;
         end
         if (!launched && bus1.start && e[3] == 1'b0) begin
            push_seq(1, 10'h300, 2, 1);
            launched = 1'b1;
         end else if (launched) begin
            bus1.start = 1'b0;
         end
      end
      vectors++;
      if (launched !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_launch: got %0d expected %0d", launched, 1);
      end
   endtask

   task automatic test_reset_mid();
      vec_t e, o;
      @(negedge clk);
      e = pop1(); o = obs1();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL rstmid_pre: got %h expected %h", o, e);
      end
      bus1.base_addr = 10'h020;
      bus1.len       = 11'd8;
      bus1.start     = 1'b1;
      push_seq(1, 10'h020, 8, 1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus1.start = 1'b0;
         e = pop1(); o = obs1();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL rstmid_cyc%0d: got %h expected %h", c, o, e);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      o = obs1();
      vectors++;
      if (o !== '0) begin
         miscompares++;
         $display("FAIL rstmid_async: got %h expected %h", o, vec_t'(0));
      end
      q1.delete();
      hold1 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         e = pop1(); o = obs1();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL rstmid_post%0d: got %h expected %h", c, o, e);
         end
      end
   endtask

   task automatic test_rdlat2();
      logic [AW-1:0] bases [2] = '{10'h055, 10'h3FF};
      int            lens  [2] = '{2, 5};
      vec_t          e, o;
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         e = pop2(); o = obs2();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL lat2_%0d_pre: got %h expected %h", t, o, e);
         end
         bus2.base_addr = bases[t];
         bus2.len       = 11'(lens[t]);
         bus2.start     = 1'b1;
         push_seq(2, bases[t], lens[t], 2);
         for (int c = 0; c < lens[t] + 6; c++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            e = pop2(); o = obs2();
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL lat2_%0d_cyc%0d: got %h expected %h", t, c, o, e);
            end
         end
      end
   endtask

   initial begin
      bus1.start = 1'b0; bus1.base_addr = '0; bus1.len = '0;
      bus2.start = 1'b0; bus2.base_addr = '0; bus2.len = '0;
      test_reset();
      test_basic();
      test_windows();
      test_back_to_back();
      test_reset_mid();
      test_rdlat2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_bram_read_sequencer

`default_nettype wire

// File: doc/bram_read_sequencer.md
# bram_read_sequencer

Upstream read controller for the 32-bit BRAM port-B capture path. On a start request it walks a contiguous address window of the block RAM, driving `addrb`/`enb`. It tracks the BRAM read latency so that `dout_valid` is aligned with `doutb` in the clock cycle it appears. It also flags the cycle in which the downstream two-word register stage holds a complete, ordered word pair.

## Interface
- `ADDR_W`, 10, BRAM address width; window length range is 0..2^ADDR_W.
- `RD_LAT`, 1, BRAM read latency in `readclk` edges; legal values are 1 and 2.

- `readclk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request pulse; sampled only while `busy`=0.
- `base_addr`  in  ADDR_W  first address; captured when `start` is accepted.
- `len`  in  ADDR_W+1  number of words to read; captured when `start` is accepted.
- `addrb`  out  ADDR_W  BRAM port-B address.
- `enb`  out  1  BRAM port-B enable.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `dout_valid`  out  1  BRAM `doutb` holds a requested word this cycle.
- `pair_valid`  out  1  downstream pair stage holds word 2j+1 (newer) and word 2j (older) this cycle.

## Operation
- States:
  - IDLE: `busy`=0.
  - READ: `enb`=1, address advancing.
  - DRAIN: `enb`=0, waiting for in-flight words.
  - DONE: single cycle, `done`=1.
- IDLE→READ: `start`=1 and `len`≠0 at a clock edge. `base_addr` and `len` are latched, and `addrb` is set to `base_addr`.
- IDLE→DONE: `start`=1 and `len`=0. No `enb` pulse is issued.
- READ: `addrb` increments by 1 at each edge. After `len` addresses are issued, the block goes to DRAIN.
- DRAIN→DONE: once the final word's `dout_valid` cycle has completed.
- DONE→IDLE: unconditionally at the next edge.
- Address arithmetic is modulo 2^ADDR_W. An address past all-ones wraps to 0 without a flag.
- `start` is ignored while `busy`=1 and has no side effects.
- In the DONE cycle, `busy`=0, so `start` is accepted in that cycle. DONE then goes directly to READ (or to DONE again if `len`=0).
- `addrb` holds its last issued value while idle.
- `pair_valid` is produced for complete pairs only. With an odd `len`, the last word gets `dout_valid` but no `pair_valid`.
- The pair counter restarts at 0 for every sequence. Pairs never straddle two sequences.
- Reset values (applied immediately when `rst_n` falls): state IDLE, `addrb`=0, `enb`=0, `busy`=0, `done`=0, `dout_valid`=0, `pair_valid`=0. Internal counters are also cleared.
- Reset mid-sequence discards in-flight reads. No `dout_valid` or `pair_valid` for them appears after reset is released.

## Timing
E0 is the edge at which `start` is accepted. "After edge X" means the cycle following that edge.
- `enb`=1 after edges E0 .. E0+len-1. `addrb` = `base_addr`+i after edge E0+i.
- `dout_valid`=1 after edges E0+RD_LAT .. E0+RD_LAT+len-1. Word i is on `doutb` after edge E0+RD_LAT+i.
- `pair_valid`=1 after edge E0+RD_LAT+2j+2, for each j with 2j+1 < len.
- `busy`=1 after edges E0 .. E0+RD_LAT+len-1.
- `done`=1 after edge E0+RD_LAT+len, for exactly one cycle.
- `len`=0 case: `done`=1 after E0, and `busy` stays 0.
- Back-to-back: a `start` accepted in the DONE cycle gives an `enb` gap of RD_LAT+1 cycles between sequences.

## Structure
- Shared package holds the state enum, the default `ADDR_W`, and the legal `RD_LAT` values.
- One sub-module, `rd_valid_pipe`: an RD_LAT-deep shift register that converts `enb` into `dout_valid` and resets asynchronously.
- The top level holds the FSM, the address and remaining-count registers, and the pair-parity bit that derives `pair_valid` from `dout_valid` delayed by one cycle.

## Test plan
- `base_addr`=0x010, `len`=4, RD_LAT=1:
  - `addrb` = 0x010..0x013 with `enb` high for 4 cycles.
  - `dout_valid` for 4 cycles starting 1 cycle later.
  - `pair_valid` twice, 2 cycles apart.
  - `done` after edge E0+5.
- `base_addr`=0x3FE, `len`=3:
  - `addrb` = 0x3FE, 0x3FF, 0x000.
  - One `pair_valid`; the third word has `dout_valid` only.
- `len`=0: `done` after E0, `enb` never asserted, `busy` stays 0.
- `start` pulsed mid-sequence: ignored, with no change to `addrb`. `start` held high through the DONE cycle: a second sequence launches immediately.
- `rst_n` dropped 2 cycles into a `len`=8 read:
  - All outputs 0 immediately.
  - After release: no `dout_valid` or `pair_valid`, state IDLE.
- RD_LAT=2, `len`=2: `dout_valid` after edges E0+2 and E0+3, `pair_valid` after E0+4, `done` after E0+4.
